// File: rtl/sw_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// sw_debounce_ctrl
//
// Debounce and edge-event controller for the synchronized switch vector.
// A prescaler produces a sample tick every TICK_DIV clocks while i_en=1.
// On each tick every switch bit is compared against its published
// (debounced) level. A per-bit counter tracks how many consecutive ticks the
// input has differed; once it has differed for STABLE_CNT ticks the new level
// is accepted. Accepted rising/falling transitions set sticky pending flags,
// which are cleared by a masked write-1-to-clear strobe. o_irq is asserted
// combinationally while any pending flag is set.
//
// Optional feature (macro SW_DEBOUNCE_IRQ_MASK_EN):
//   Adds i_mask_we / i_mask_data and a WIDTH-bit interrupt mask register
//   (reset to all ones). Masked bits still record pending flags but do not
//   contribute to o_irq. Without the macro every pending bit drives o_irq.
//
// Reset is asynchronous and active-low (i_reset); everything runs on i_clk.
// ---------------------------------------------------------------------------
module sw_debounce_ctrl #(
    parameter int WIDTH      = 32,
    parameter int TICK_DIV   = 1000,  // legal range 1 .. 2**20
    parameter int STABLE_CNT = 4      // legal range 1 .. 15
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_sw,
    input  logic             i_en,
    input  logic             i_clr_we,
    input  logic [WIDTH-1:0] i_clr_mask,
`ifdef SW_DEBOUNCE_IRQ_MASK_EN
    input  logic             i_mask_we,
    input  logic [WIDTH-1:0] i_mask_data,
`endif
    output logic [WIDTH-1:0] o_sw_stable,
    output logic [WIDTH-1:0] o_sw_rise,
    output logic [WIDTH-1:0] o_sw_fall,
    output logic             o_irq
);

    // -----------------------------------------------------------------------
    // Widths and terminal counts
    // -----------------------------------------------------------------------
    // A one-bit prescaler is kept even for TICK_DIV=1; it then simply stays 0.
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_CNT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    // -----------------------------------------------------------------------
    // Prescaler
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;
    logic             tick;

    assign tick = i_en && (div_cnt_reg == DIV_LAST);

    // Count 0..TICK_DIV-1 while enabled; parked at 0 while disabled.
    always_comb begin
        div_cnt_next = '0;
        if (i_en && !tick) begin
            div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
    end

    // Prescaler state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Debounced level and pending flag registers
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] stable_reg;
    logic [WIDTH-1:0] stable_next;
    logic [WIDTH-1:0] rise_reg;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_reg;
    logic [WIDTH-1:0] fall_next;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] irq_en_mask;

    // -----------------------------------------------------------------------
    // Per-bit stability counters
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             differs;

            assign differs = i_sw[gi] ^ stable_reg[gi];

            // The new level is accepted on the tick that would have been the
            // STABLE_CNT-th consecutive differing sample.
            assign accept[gi] = tick && differs && (cnt_reg == CNT_LAST);

            // Advance on differing ticks, restart on agreement or acceptance,
            // and drop any partial count while sampling is disabled.
            always_comb begin
                cnt_next = cnt_reg;
                if (!i_en) begin
                    cnt_next = '0;
                end else if (tick) begin
                    if (!differs || (cnt_reg == CNT_LAST)) begin
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            // Stability counter register for this bit.
            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state for levels and pending flags
    // -----------------------------------------------------------------------
    // An accepted bit always differs from its current level, so toggling the
    // accepted bits yields the new debounced vector. A set arriving in the
    // same cycle as a clear on that bit wins because it is ORed in last.
    always_comb begin
        clr_bits    = i_clr_we ? i_clr_mask : '0;
        stable_next = stable_reg ^ accept;
        rise_next   = (rise_reg & ~clr_bits) | (accept & i_sw);
        fall_next   = (fall_reg & ~clr_bits) | (accept & ~i_sw);
    end

    // Debounced level and sticky pending flag registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stable_reg <= '0;
            rise_reg   <= '0;
            fall_reg   <= '0;
        end else begin
            stable_reg <= stable_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
        end
    end

    // -----------------------------------------------------------------------
    // Interrupt mask
    // -----------------------------------------------------------------------
`ifdef SW_DEBOUNCE_IRQ_MASK_EN
    logic [WIDTH-1:0] mask_reg;

    // Interrupt mask register, all bits enabled out of reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            mask_reg <= '1;
        end else if (i_mask_we) begin
            mask_reg <= i_mask_data;
        end
    end

    assign irq_en_mask = mask_reg;
`else
    assign irq_en_mask = '1;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_sw_stable = stable_reg;
    assign o_sw_rise   = rise_reg;
    assign o_sw_fall   = fall_reg;
    assign o_irq       = |((rise_reg | fall_reg) & irq_en_mask);

endmodule

// File: doc/sw_debounce_ctrl.md
Name: sw_debounce_ctrl

Overview:
- Debounce and event controller that sits after the switch synchronizer register, between it and the switch MMIO read path.
- Samples the synchronized switch vector on a programmable prescaler tick and filters each bit through a stability counter.
- Publishes a debounced switch vector and records rising and falling edges in sticky pending registers.
- Raises a level interrupt while any edge is pending. Pending bits are cleared by a masked write-1-to-clear strobe from the LSU.

Parameters:
- WIDTH, 32, number of switch bits.
- TICK_DIV, 1000, clocks per sample tick; legal range 1 to 2^20.
- STABLE_CNT, 4, consecutive differing samples needed to accept a new level; legal range 1 to 15.

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  reset, asynchronous, active-low.
- i_sw  input  WIDTH  switch vector, already synchronized to i_clk.
- i_en  input  1  enable for sampling and debouncing.
- i_clr_we  input  1  pending-clear strobe, one cycle.
- i_clr_mask  input  WIDTH  bits whose pending rise/fall flags are cleared when i_clr_we=1.
- o_sw_stable  output  WIDTH  debounced switch levels.
- o_sw_rise  output  WIDTH  sticky rising-edge pending flags.
- o_sw_fall  output  WIDTH  sticky falling-edge pending flags.
- o_irq  output  1  level interrupt.

Behaviour:
- Reset (i_reset=0, asynchronous): o_sw_stable, o_sw_rise, o_sw_fall, the prescaler and all per-bit counters go to 0. o_irq=0.
- Reset asserted mid-debounce discards partial counts. No edge is reported for levels that were pending acceptance.

Prescaler:
- div_cnt counts 0..TICK_DIV-1 while i_en=1.
- tick=1 in the cycle where div_cnt==TICK_DIV-1; div_cnt returns to 0 at that edge.
- TICK_DIV=1 gives a tick every cycle.
- i_en=0: div_cnt held at 0, no ticks, all per-bit counters cleared. o_sw_stable and the pending flags are retained.
- First tick after i_en rises occurs TICK_DIV-1 cycles later.

Per bit b, evaluated only on tick edges:
- If i_sw[b]==o_sw_stable[b]: cnt[b] <= 0.
- Else if cnt[b]==STABLE_CNT-1: o_sw_stable[b] <= i_sw[b] and cnt[b] <= 0.
  - Set o_sw_rise[b] if the new level is 1; set o_sw_fall[b] if the new level is 0.
- Else: cnt[b] <= cnt[b]+1.
- Counter width is $clog2(STABLE_CNT+1). The counter never wraps.

Latency:
- A level held constant from a tick onward is accepted on its STABLE_CNT-th consecutive tick.
- o_sw_stable and the pending flag update at that same clock edge.

Pending flags:
- Sticky until cleared. Clearing takes effect at the edge where i_clr_we=1, for bits with i_clr_mask=1.
- Simultaneous set and clear on the same bit in the same cycle: set wins.
- Clears on other bits are unaffected.
- i_clr_we=1 with mask 0 is a no-op.

Interrupt:
- o_irq is combinational: OR-reduction of (o_sw_rise | o_sw_fall), qualified by the IRQ mask if present.
- It follows the pending registers in the same cycle and has no extra latency.

Other rules:
- Bits are independent. Any number of bits may accept new levels on the same tick.
- i_clr_we is ignored while i_reset=0.

Optional Feature:
- Macro SW_DEBOUNCE_IRQ_MASK_EN.
- Defined:
  - Adds ports i_mask_we (input, 1) and i_mask_data (input, WIDTH).
  - Adds a WIDTH-bit mask register: reset value all ones, loaded from i_mask_data at the edge where i_mask_we=1.
  - o_irq = |((o_sw_rise|o_sw_fall) & mask).
  - Masked bits still set pending flags but do not drive o_irq.
- Undefined: ports and register are absent; o_irq = |(o_sw_rise|o_sw_fall).

Test Plan (TICK_DIV=4, STABLE_CNT=3, WIDTH=32, i_en=1 unless noted):
1. Reset release, i_sw=0 held 20 cycles -> o_sw_stable=0, o_sw_rise=0, o_sw_fall=0, o_irq=0 throughout. A tick occurs every 4th cycle.
2. i_sw=0x0000_0001 set right after a tick and held -> o_sw_stable[0]=1, o_sw_rise=0x1 and o_irq=1 at the 3rd following tick edge, not earlier.
3. i_sw[5] pulsed high for exactly 2 ticks then low -> o_sw_stable[5] stays 0, no pending flag, o_irq=0.
4. With o_sw_rise=0x1, assert i_clr_we=1 with i_clr_mask=0x1 -> o_sw_rise=0 and o_irq=0 next cycle. Repeat with the clear coinciding with a new accept on bit 0 -> flag remains 1.
5. i_sw=0x0000_0003 held for 2 ticks, then i_reset pulsed low -> all outputs 0 at once. After release, 3 fresh ticks are needed before o_sw_stable=0x3.
6. i_sw[2]=1 held, i_en dropped after 2 ticks for 10 cycles, then raised -> no accept while i_en=0. Accept occurs 3 ticks after re-enable, first tick 3 cycles after i_en rises.
